// File: rtl/block_stream_gen_pkg.sv
// Shared op codes, FSM states, ASCII constants and word lengths for the
// begin/end block stream generator.
package block_stream_pkg;

    typedef enum logic [1:0] {
        OP_BEGIN = 2'b00,
        OP_END   = 2'b01,
        OP_SPACE = 2'b10,
        OP_JUNK  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_SEP  = 2'b10
    } state_t;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    localparam logic [2:0] LEN_BEGIN = 3'd5;
    localparam logic [2:0] LEN_END   = 3'd3;
    localparam logic [2:0] LEN_JUNK  = 3'd3;
    localparam logic [2:0] LEN_SPACE = 3'd0;

    function automatic logic [2:0] wordLen(input op_t op);
        case (op)
            OP_BEGIN: wordLen = LEN_BEGIN;
            OP_END:   wordLen = LEN_END;
            OP_JUNK:  wordLen = LEN_JUNK;
            default:  wordLen = LEN_SPACE;
        endcase
    endfunction

endpackage

// File: rtl/block_stream_gen_if.sv
// Command and character handshakes plus reference status of the block stream
// generator; master is the generator side, slave is the command source/consumer.
interface block_stream_gen_if #(
    parameter int DEPTH_W = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [4:0]                cmd_case;
    logic                      char_valid;
    logic                      char_ready;
    logic [7:0]                char_data;
    logic signed [DEPTH_W-1:0] depth;
    logic                      broken;
    logic                      expect_ok;

    modport master (
        input  cmd_valid, cmd_op, cmd_case, char_ready,
        output cmd_ready, char_valid, char_data, depth, broken, expect_ok
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_case, char_ready,
        input  cmd_ready, char_valid, char_data, depth, broken, expect_ok
    );
endinterface

// File: rtl/block_stream_gen_word_rom.sv
// Combinational word ROM: (op, character index, case bit) -> ASCII byte and a
// flag marking the last character of the word.
module block_word_rom
    import block_stream_pkg::*;
(
    input  op_t        i_op,
    input  logic [2:0] i_idx,
    input  logic       i_upper,
    output logic [7:0] o_byte,
    output logic       o_last
);

    logic [7:0] w_lower;
    logic       w_inWord;

    always_comb begin
        w_lower = ASCII_SP;
        case (i_op)
            OP_BEGIN: begin
                case (i_idx)
                    3'd0:    w_lower = 8'h62;
                    3'd1:    w_lower = 8'h65;
                    3'd2:    w_lower = 8'h67;
                    3'd3:    w_lower = 8'h69;
                    3'd4:    w_lower = 8'h6E;
                    default: w_lower = ASCII_SP;
                endcase
            end
            OP_END: begin
                case (i_idx)
                    3'd0:    w_lower = 8'h65;
                    3'd1:    w_lower = 8'h6E;
                    3'd2:    w_lower = 8'h64;
                    default: w_lower = ASCII_SP;
                endcase
            end
            OP_JUNK: begin
                case (i_idx)
                    3'd0:    w_lower = 8'h62;
                    3'd1:    w_lower = 8'h65;
                    3'd2:    w_lower = 8'h67;
                    default: w_lower = ASCII_SP;
                endcase
            end
            default: w_lower = ASCII_SP;
        endcase
    end

    // Case bits only apply inside the word, so the padding space is never shifted.
    assign w_inWord = (i_idx < wordLen(i_op));
    assign o_byte   = (w_inWord && i_upper) ? (w_lower - CASE_OFFSET) : w_lower;
    assign o_last   = (i_idx == (wordLen(i_op) - 3'd1));

endmodule

// File: rtl/block_stream_gen.sv
// Byte-serial ASCII stream generator for begin/end words, with a reference
// nesting depth and sticky underflow flag committed at each word's trailing space.
module block_stream_gen
    import block_stream_pkg::*;
#(
    parameter int DEPTH_W = 32
)(
    input logic                 clk,
    input logic                 reset,
    block_stream_gen_if.master  bus
);

    localparam logic signed [DEPTH_W-1:0] DEPTH_MAX  = {1'b0, {(DEPTH_W-1){1'b1}}};
    localparam logic signed [DEPTH_W-1:0] DEPTH_ZERO = '0;
    localparam logic signed [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_t                    r_state;
    op_t                       r_op;
    logic [4:0]                r_case;
    logic [2:0]                r_idx;
    logic                      r_last;
    logic                      r_charValid;
    logic [7:0]                r_charData;
    logic signed [DEPTH_W-1:0] r_depth;
    logic                      r_broken;

    logic       w_accept;
    op_t        w_romOp;
    logic [2:0] w_nextIdx;
    logic [7:0] w_maskExt;
    logic [7:0] w_romByte;
    logic       w_romLast;

    // The ROM looks one character ahead so the next byte can be registered.
    assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_romOp   = w_accept ? op_t'(bus.cmd_op) : r_op;
    assign w_nextIdx = w_accept ? 3'd0 : (r_idx + 3'd1);
    assign w_maskExt = {3'b000, (w_accept ? bus.cmd_case : r_case)};

    block_word_rom u_rom (
        .i_op    (w_romOp),
        .i_idx   (w_nextIdx),
        .i_upper (w_maskExt[w_nextIdx]),
        .o_byte  (w_romByte),
        .o_last  (w_romLast)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_SPACE;
            r_case      <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_charValid <= 1'b0;
            r_charData  <= ASCII_SP;
            r_depth     <= DEPTH_ZERO;
            r_broken    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op        <= op_t'(bus.cmd_op);
                        r_case      <= bus.cmd_case;
                        r_idx       <= 3'd0;
                        r_charValid <= 1'b1;
                        if (op_t'(bus.cmd_op) == OP_SPACE) begin
                            r_state    <= ST_SEP;
                            r_charData <= ASCII_SP;
                        end else begin
                            r_state    <= ST_EMIT;
                            r_charData <= w_romByte;
                            r_last     <= w_romLast;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.char_ready) begin
                        if (r_last) begin
                            r_state    <= ST_SEP;
                            r_charData <= ASCII_SP;
                        end else begin
                            r_idx      <= w_nextIdx;
                            r_charData <= w_romByte;
                            r_last     <= w_romLast;
                        end
                    end
                end
                ST_SEP: begin
                    if (bus.char_ready) begin
                        r_state     <= ST_IDLE;
                        r_charValid <= 1'b0;
                        // Depth only moves once the whole word has left the block.
                        case (r_op)
                            OP_BEGIN: if (r_depth != DEPTH_MAX) r_depth <= r_depth + DEPTH_ONE;
                            OP_END: begin
                                if (r_depth == DEPTH_ZERO) r_broken <= 1'b1;
                                else                       r_depth  <= r_depth - DEPTH_ONE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_charValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.char_valid = r_charValid;
    assign bus.char_data  = r_charData;
    assign bus.depth      = r_depth;
    assign bus.broken     = r_broken;
    assign bus.expect_ok  = (r_depth == DEPTH_ZERO) && !r_broken;

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed bench for block_stream_gen: a table of words with hand-computed
// byte streams and status, plus reset, stall and back-to-back sequences.
module tb_block_stream_gen;
    import block_stream_pkg::*;

    typedef struct {
        logic [1:0] op;
        logic [4:0] cs;
        int         len;
        logic [7:0] bytes [6];
        int         depth;
        logic       broken;
        logic       ok;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    block_stream_gen_if #(.DEPTH_W(32)) bus ();

    block_stream_gen #(.DEPTH_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_case   = 5'b00000;
        bus.char_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Offer a command from a negedge and return just after it is accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] cs);
        bit accepted;
        accepted      = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_case  = cs;
        for (int k = 0; k < 20 && !accepted; k++) begin
            if (bus.cmd_ready) accepted = 1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!accepted) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic collectWord(input string tag, output logic [7:0] got [8], output int n);
        bit done;
        done = 0;
        n    = 0;
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        bus.char_ready = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput({tag, " firstCharLatency"}, 64'(bus.char_valid), 64'd1);
            if (bus.char_valid) begin
                if (n < 8) got[n] = bus.char_data;
                n++;
                if (bus.char_data == ASCII_SP) done = 1;
            end
        end
        if (!done) checkOutput({tag, " wordTimeout"}, 0, 1);
        @(negedge clk);
        checkOutput({tag, " idleAfterSpace"}, 64'({bus.char_valid, bus.cmd_ready}), 64'b01);
    endtask

    vec_t       vecs [14];
    logic [7:0] got [8];
    logic [7:0] stream [32];
    logic [7:0] expStream [26];
    logic [3:0] pat;
    logic [1:0] b2bOps [5];
    logic [7:0] prevData;
    int         n;
    int         stableErr;
    int         readyErr;
    int         opIdx;
    bit         prevStall;

    initial begin
        checks = 0;
        fails  = 0;

        vecs[0]  = '{OP_BEGIN, 5'b00000, 6, '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20}, 1, 1'b0, 1'b0};
        vecs[1]  = '{OP_END,   5'b00111, 4, '{8'h45, 8'h4E, 8'h44, 8'h20, 8'h00, 8'h00}, 0, 1'b0, 1'b1};
        vecs[2]  = '{OP_JUNK,  5'b00101, 4, '{8'h42, 8'h65, 8'h47, 8'h20, 8'h00, 8'h00}, 0, 1'b0, 1'b1};
        vecs[3]  = '{OP_SPACE, 5'b11111, 1, '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b1};
        vecs[4]  = '{OP_BEGIN, 5'b11111, 6, '{8'h42, 8'h45, 8'h47, 8'h49, 8'h4E, 8'h20}, 1, 1'b0, 1'b0};
        vecs[5]  = '{OP_BEGIN, 5'b01010, 6, '{8'h62, 8'h45, 8'h67, 8'h49, 8'h6E, 8'h20}, 2, 1'b0, 1'b0};
        vecs[6]  = '{OP_BEGIN, 5'b10000, 6, '{8'h62, 8'h65, 8'h67, 8'h69, 8'h4E, 8'h20}, 3, 1'b0, 1'b0};
        vecs[7]  = '{OP_END,   5'b11000, 4, '{8'h65, 8'h6E, 8'h64, 8'h20, 8'h00, 8'h00}, 2, 1'b0, 1'b0};
        vecs[8]  = '{OP_JUNK,  5'b11010, 4, '{8'h62, 8'h45, 8'h67, 8'h20, 8'h00, 8'h00}, 2, 1'b0, 1'b0};
        vecs[9]  = '{OP_END,   5'b00010, 4, '{8'h65, 8'h4E, 8'h64, 8'h20, 8'h00, 8'h00}, 1, 1'b0, 1'b0};
        vecs[10] = '{OP_END,   5'b00001, 4, '{8'h45, 8'h6E, 8'h64, 8'h20, 8'h00, 8'h00}, 0, 1'b0, 1'b1};
        vecs[11] = '{OP_END,   5'b00000, 4, '{8'h65, 8'h6E, 8'h64, 8'h20, 8'h00, 8'h00}, 0, 1'b1, 1'b0};
        vecs[12] = '{OP_BEGIN, 5'b00000, 6, '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20}, 1, 1'b1, 1'b0};
        vecs[13] = '{OP_END,   5'b00000, 4, '{8'h65, 8'h6E, 8'h64, 8'h20, 8'h00, 8'h00}, 0, 1'b1, 1'b0};

        // Reset values while reset is held.
        reset          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_case   = 5'b00000;
        bus.char_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst cmd_ready",  64'(bus.cmd_ready),  64'd1);
        checkOutput("rst char_valid", 64'(bus.char_valid), 64'd0);
        checkOutput("rst char_data",  64'(bus.char_data),  64'h20);
        checkOutput("rst depth",      64'(bus.depth),      64'd0);
        checkOutput("rst broken",     64'(bus.broken),     64'd0);
        checkOutput("rst expect_ok",  64'(bus.expect_ok),  64'd1);
        reset = 1'b1;
        @(negedge clk);

        // Reset in the middle of a BEGIN, then restart.
        applyStimulus(OP_BEGIN, 5'b00000);
        bus.char_ready = 1'b1;
        @(negedge clk);
        checkOutput("midRst char0", 64'(bus.char_data), 64'h62);
        @(negedge clk);
        checkOutput("midRst char1", 64'(bus.char_data), 64'h65);
        reset = 1'b0;
        #1;
        checkOutput("midRst char_valid", 64'(bus.char_valid), 64'd0);
        checkOutput("midRst cmd_ready",  64'(bus.cmd_ready),  64'd1);
        checkOutput("midRst depth",      64'(bus.depth),      64'd0);
        checkOutput("midRst expect_ok",  64'(bus.expect_ok),  64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(OP_BEGIN, 5'b00000);
        collectWord("restart", got, n);
        checkOutput("restart len",   64'(n),         64'd6);
        checkOutput("restart char0", 64'(got[0]),    64'h62);
        checkOutput("restart depth", 64'(bus.depth), 64'd1);

        // BEGIN with char_ready stalling in a 1,0,0,1 pattern; depth 1 -> 2.
        pat       = 4'b1001;
        stableErr = 0;
        readyErr  = 0;
        prevStall = 0;
        prevData  = 8'h00;
        n         = 0;
        applyStimulus(OP_BEGIN, 5'b00000);
        for (int k = 0; k < 60 && n < 6; k++) begin
            @(negedge clk);
            bus.char_ready = pat[k % 4];
            if (prevStall && (!bus.char_valid || bus.char_data !== prevData)) stableErr++;
            if (bus.cmd_ready) readyErr++;
            if (bus.char_valid && bus.char_ready) begin
                got[n] = bus.char_data;
                n++;
            end
            prevStall = bus.char_valid && !bus.char_ready;
            prevData  = bus.char_data;
        end
        @(negedge clk);
        checkOutput("stall len",       64'(n),         64'd6);
        checkOutput("stall holdErrors", 64'(stableErr), 64'd0);
        checkOutput("stall cmdReadyEarly", 64'(readyErr), 64'd0);
        for (int i = 0; i < 6 && i < n; i++)
            checkOutput($sformatf("stall byte%0d", i), 64'(got[i]), 64'(vecs[0].bytes[i]));
        checkOutput("stall cmd_ready after", 64'(bus.cmd_ready), 64'd1);
        checkOutput("stall depth",     64'(bus.depth), 64'd2);
        bus.char_ready = 1'b1;

        // END as the very first command underflows.
        doReset();
        applyStimulus(OP_END, 5'b00000);
        collectWord("endFirst", got, n);
        checkOutput("endFirst len", 64'(n), 64'd4);
        checkOutput("endFirst bytes", {32'h0, got[0], got[1], got[2], got[3]}, 64'h656E6420);
        checkOutput("endFirst broken",    64'(bus.broken),    64'd1);
        checkOutput("endFirst depth",     64'(bus.depth),     64'd0);
        checkOutput("endFirst expect_ok", 64'(bus.expect_ok), 64'd0);

        // Table of words applied from a clean reset.
        doReset();
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].op, vecs[v].cs);
            collectWord($sformatf("vec%0d", v), got, n);
            checkOutput($sformatf("vec%0d len", v), 64'(n), 64'(vecs[v].len));
            for (int i = 0; i < vecs[v].len && i < n; i++)
                checkOutput($sformatf("vec%0d byte%0d", v, i), 64'(got[i]), 64'(vecs[v].bytes[i]));
            checkOutput($sformatf("vec%0d depth", v),     64'(bus.depth),     64'(vecs[v].depth));
            checkOutput($sformatf("vec%0d broken", v),    64'(bus.broken),    64'(vecs[v].broken));
            checkOutput($sformatf("vec%0d expect_ok", v), 64'(bus.expect_ok), 64'(vecs[v].ok));
        end

        // BEGIN x3 then END x2 with cmd_valid held high the whole time.
        doReset();
        b2bOps = '{OP_BEGIN, OP_BEGIN, OP_BEGIN, OP_END, OP_END};
        for (int w = 0; w < 3; w++) begin
            expStream[w*6+0] = 8'h62; expStream[w*6+1] = 8'h65; expStream[w*6+2] = 8'h67;
            expStream[w*6+3] = 8'h69; expStream[w*6+4] = 8'h6E; expStream[w*6+5] = 8'h20;
        end
        for (int w = 0; w < 2; w++) begin
            expStream[18+w*4+0] = 8'h65; expStream[18+w*4+1] = 8'h6E;
            expStream[18+w*4+2] = 8'h64; expStream[18+w*4+3] = 8'h20;
        end
        opIdx          = 0;
        n              = 0;
        readyErr       = 0;
        bus.char_ready = 1'b1;
        for (int k = 0; k < 200 && n < 26; k++) begin
            @(negedge clk);
            bus.cmd_valid = (opIdx < 5);
            bus.cmd_op    = b2bOps[opIdx < 5 ? opIdx : 4];
            bus.cmd_case  = 5'b00000;
            if (bus.cmd_ready && bus.char_valid) readyErr++;
            if (bus.char_valid) begin
                if (n < 32) stream[n] = bus.char_data;
                n++;
            end
            if (bus.cmd_valid && bus.cmd_ready) opIdx++;
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b accepts",  64'(opIdx),    64'd5);
        checkOutput("b2b len",      64'(n),        64'd26);
        checkOutput("b2b readyOverlap", 64'(readyErr), 64'd0);
        for (int i = 0; i < 26 && i < n; i++)
            checkOutput($sformatf("b2b byte%0d", i), 64'(stream[i]), 64'(expStream[i]));
        checkOutput("b2b depth",     64'(bus.depth),     64'd1);
        checkOutput("b2b broken",    64'(bus.broken),    64'd0);
        checkOutput("b2b expect_ok", 64'(bus.expect_ok), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/block_stream_gen.md
Name: block_stream_gen

Overview:
- Transmit-side counterpart of the begin/end block checker.
- Turns word-level commands into a byte-serial ASCII stream, one character per accepted handshake, with a single trailing space after every word.
- Keeps a reference nesting depth and a sticky-underflow flag, so benches can compare the checker's result against a known-good expectation.
- Sits between a test/command source and any ASCII consumer.

Parameters:
- DEPTH_W, 32, width of the signed nesting-depth counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_op  input  2  00 BEGIN, 01 END, 10 SPACE, 11 JUNK
- cmd_case  input  5  bit i = 1 makes character i of the word uppercase
- char_valid  output  1  char_data is valid
- char_ready  input  1  consumer takes the character
- char_data  output  8  ASCII byte
- depth  output  DEPTH_W  signed count: BEGINs minus ENDs completed
- broken  output  1  sticky; set when depth would drop below 0
- expect_ok  output  1  equals (depth == 0 && !broken)

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE; char_valid = 0; char_data = 8'h20; depth = 0; broken = 0.
  - Therefore expect_ok = 1 and cmd_ready = 1.
  - Reset asserted mid-word abandons the word immediately. No partial depth update.
- States: IDLE, EMIT, SEP.
- IDLE:
  - cmd_ready = 1, char_valid = 0.
  - On accept, latch op, case mask and char index = 0. Next state is EMIT (SEP for op SPACE).
- Words by op:
  - BEGIN = "begin", 5 chars.
  - END = "end", 3 chars.
  - JUNK = "beg", 3 chars (a prefix the checker must reject).
  - SPACE = zero chars.
- Casing: character i is uppercase (byte - 8'h20) when cmd_case[i] = 1. Mask bits beyond the word length are ignored.
- EMIT:
  - char_valid = 1; char_data = current character.
  - char_data is held stable while char_valid && !char_ready.
  - On handshake, index increments. After the last character's handshake, go to SEP.
- SEP:
  - char_valid = 1; char_data = 8'h20.
  - On handshake, go to IDLE and commit depth/broken.
- Latency and throughput:
  - First character is valid in the cycle after command accept.
  - With char_ready held at 1, BEGIN takes 7 cycles from accept to the next cmd_ready.
  - cmd_ready = 0 outside IDLE; no command buffering.
- Depth commit, at the SEP handshake only:
  - BEGIN: depth + 1.
  - END when depth == 0: set broken. depth stays at 0, and broken never clears except by reset.
  - END otherwise: depth - 1.
  - JUNK and SPACE: no change.
- Depth wrap: at DEPTH_W max positive, BEGIN saturates (depth is not incremented).
- char_valid never drops without a handshake, except under reset.
- cmd_valid is ignored outside IDLE.

Decomposition:
- Package block_stream_pkg:
  - Op code constants OP_BEGIN/OP_END/OP_SPACE/OP_JUNK.
  - State encoding.
  - ASCII constants (ASCII_SP, case offset 8'h20).
  - Word length constants (5, 3, 3, 0).
- One sub-module, block_word_rom: combinational (op, index, case bit) -> byte plus last-char flag.

Test Plan:
- Reset low mid-EMIT of BEGIN, then release. Required: char_valid = 0 immediately, depth = 0, expect_ok = 1, next accept restarts at 'b'.
- BEGIN with cmd_case = 5'b00000, then END with 5'b00111, char_ready = 1. Required stream: 62 65 67 69 6E 20 45 4E 44 20. depth goes 1 then 0; expect_ok ends at 1.
- END as the first command. Required: stream 65 6E 64 20; broken = 1 after the space; depth = 0; expect_ok = 0. A following BEGIN/END pair leaves broken = 1.
- BEGIN with char_ready toggling 1,0,0,1 per cycle. Required: each byte held stable through stalls, no byte lost or duplicated, cmd_ready = 0 until the space handshake.
- JUNK with cmd_case = 5'b00101, then SPACE. Required: stream 42 65 47 20 20; depth unchanged; each op followed by exactly one 8'h20.
- BEGIN ×3 then END ×2. Required: depth = 1 and expect_ok = 0 after the final space; back-to-back cmd_valid is accepted only in IDLE.
